ej32_ram_dump: RTL and testbench
================================

# ej32_ram_dump

Bus-master reader that streams a contiguous byte region of the 8-bit SPRAM out over a valid/ready byte port, with a running 16-bit checksum. It is the read-side counterpart of the ROM-to-RAM image loader. Typical uses:
- verifying a loaded eForth image,
- draining the output buffer (OBUF) to a serial transmitter.

It sits beside the core on the 8-bit memory bus and must only be started while the core is not driving that bus.

## Interface
Parameters:
- ASZ, 17: address width (128KB space).
- SETTLE, 0: idle cycles inserted after start, before the first read, for memory read stabilization. Maximum value is 255.

Ports:
- clk  in  1  system clock; SPRAM is clocked on the falling edge of this clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  begin a dump; sampled only in IDLE.
- src_a  in  ASZ  first byte address, latched on start.
- len  in  ASZ  byte count, latched on start; 0 is legal.
- abort  in  1  terminate an active dump.
- bus_req  out  1  read strobe to the 8-bit memory bus.
- bus_a  out  ASZ  read address; 0 whenever bus_req=0.
- bus_vo  in  8  read data; valid in the cycle after bus_req.
- tx_d  out  8  output byte.
- tx_vld  out  1  tx_d valid.
- tx_rdy  in  1  sink accepts tx_d.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- sum  out  16  byte sum mod 2^16 of bytes read so far; held after done until the next start.

## Operation
The block is a state machine with six states: IDLE, SETTLE, FETCH, CAPTURE, OUT, DONE.

- **IDLE**
  - On start=1: latch a<=src_a, n<=len, sum<=0, wcnt<=SETTLE.
  - Next state: DONE if len==0; else SETTLE if SETTLE!=0; else FETCH.
- **SETTLE**
  - wcnt decrements each cycle.
  - Goes to FETCH in the cycle after wcnt reaches 0, so SETTLE occupies exactly SETTLE cycles.
- **FETCH**
  - Outputs bus_req=1, bus_a=a.
  - Next state: CAPTURE.
- **CAPTURE**
  - Registers: tx_d<=bus_vo, sum<=sum+bus_vo, a<=a+1, n<=n-1.
  - Next state: OUT.
- **OUT**
  - Outputs tx_vld=1.
  - If tx_rdy=1: go to DONE when n==0, else go to FETCH.
  - If tx_rdy=0: stay in OUT holding tx_d unchanged.
- **DONE**
  - Outputs done=1.
  - Next state: IDLE.

Rules:
- start is ignored while busy=1.
- abort=1 in SETTLE, FETCH, CAPTURE or OUT forces DONE on the next cycle.
  - abort beats tx_rdy: a byte offered in the same cycle is not transferred.
  - sum keeps any captured byte, including an offered-but-untransferred one.
  - A read already issued is dropped.
  - abort in IDLE or DONE has no effect.
- Address arithmetic is mod 2^ASZ: 0x1FFFF+1 = 0x00000 (ASZ=17).
- The block never writes memory.

## Timing
- Reset: state=IDLE. bus_req, bus_a, tx_d, tx_vld, busy, done and sum are all 0; internal a, n and wcnt are 0. Asserting rst mid-dump returns the block to IDLE on the next edge with no done pulse.
- With start at cycle 0, SETTLE=0 and tx_rdy held at 1:
  - FETCH occurs in cycle 1 + 3k;
  - byte k is offered in cycle 3 + 3k;
  - done occurs in cycle 3·len + 1.
- Throughput is one byte per 3 cycles. Each stalled cycle in OUT adds one cycle.
- SETTLE=s shifts every event by s cycles.
- len=0: done is high in cycle 1 and no bus_req is issued.
- tx_d and tx_vld are registered. tx_d is stable for the whole time tx_vld=1. A transfer occurs on any edge where tx_vld=1 and tx_rdy=1.
- At most one bus_req is outstanding. There is no bus_req while in OUT.
- busy is high from the cycle after start through the DONE cycle inclusive.

## Test plan
- **Basic dump.** Preload 0x1400..0x1403 with 10, 11, 12, 13 (hex). Start with src_a=0x1400, len=4, tx_rdy=1. Required: bytes 10, 11, 12, 13 offered at cycles 3, 6, 9, 12; done at cycle 13; sum=0x0046.
- **Zero length.** Start with len=0. Required: bus_req never asserted, tx_vld stays 0, done at cycle 1, sum=0.
- **Backpressure and ignored start.** Hold tx_rdy=0 for 5 cycles while the first byte is offered. Required:
  - tx_vld and tx_d held steady for all 5 cycles;
  - no bus_req during the stall;
  - a start pulse during the stall is ignored;
  - the full sequence completes after tx_rdy is released.
- **Wrap and checksum overflow.** src_a=0x1FFFF, len=2 → reads 0x1FFFF then 0x00000. Then fill 300 bytes with 0xFF and dump them → final sum=0x2AD4.
- **Abort.** Assert abort in the OUT state of byte 1 of a len=4 dump, with tx_rdy=1. Required:
  - byte 1 is not transferred;
  - done on the next cycle;
  - tx_vld=0 afterwards;
  - a following start with len=1 completes normally.
- **Reset mid-operation.** Assert rst in CAPTURE. Required: all outputs return to 0 on the next cycle, no done pulse, and IDLE accepts a new start.

Source files
------------

// File: rtl/ej32_ram_dump_if.sv
// Bus and byte-stream signals of the SPRAM dump engine.
// The dump engine uses the master view: it drives the memory bus and the byte stream.
// The slave view is used by the environment: the memory, the byte sink and the controller.
interface ej32_ram_dump_if #(
  parameter int ASZ = 17
);
  logic           start;
  logic [ASZ-1:0] src_a;
  logic [ASZ-1:0] len;
  logic           abort;
  logic           bus_req;
  logic [ASZ-1:0] bus_a;
  logic [7:0]     bus_vo;
  logic [7:0]     tx_d;
  logic           tx_vld;
  logic           tx_rdy;
  logic           busy;
  logic           done;
  logic [15:0]    sum;

  modport master (
    input  start, src_a, len, abort, bus_vo, tx_rdy,
    output bus_req, bus_a, tx_d, tx_vld, busy, done, sum
  );

  modport slave (
    output start, src_a, len, abort, bus_vo, tx_rdy,
    input  bus_req, bus_a, tx_d, tx_vld, busy, done, sum
  );
endinterface

// File: rtl/ej32_ram_dump.sv
// Streams a contiguous SPRAM byte region out over a valid/ready port.
// It also keeps a running 16-bit byte checksum of the region.
// Each byte costs three cycles: FETCH (read strobe), CAPTURE (register the data), OUT (offer the byte).
module ej32_ram_dump #(
  parameter int ASZ    = 17,
  parameter int SETTLE = 0
) (
  input logic              clk,
  input logic              rst,
  ej32_ram_dump_if.master  io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FETCH,
    S_CAPTURE,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t         state, state_nxt;
  logic [ASZ-1:0] a;
  logic [ASZ-1:0] n;
  logic [7:0]     wcnt;
  logic [7:0]     tx_d_q;
  logic           tx_vld_q;
  logic [15:0]    sum_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection; abort overrides everything once a dump has started.
  always_comb begin
    // NOTE: a default is assigned before the case, so no path leaves state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (io.start) begin
          if (io.len == '0)           state_nxt = S_DONE;
          else if (SETTLE_CNT != 8'd0) state_nxt = S_SETTLE;
          else                        state_nxt = S_FETCH;
        end
      end
      S_SETTLE: begin
        if (io.abort)              state_nxt = S_DONE;
        else if (wcnt <= 8'd1)     state_nxt = S_FETCH;
      end
      S_FETCH:   state_nxt = io.abort ? S_DONE : S_CAPTURE;
      S_CAPTURE: state_nxt = io.abort ? S_DONE : S_OUT;
      S_OUT: begin
        if (io.abort)       state_nxt = S_DONE;
        else if (io.tx_rdy) state_nxt = (n == '0) ? S_DONE : S_FETCH;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the job on start, count settle cycles, and capture read data.
  // An abort in CAPTURE drops the read that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      n        <= '0;
      wcnt     <= '0;
      tx_d_q   <= '0;
      tx_vld_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      tx_vld_q <= (state_nxt == S_OUT);
      unique case (state)
        S_IDLE: begin
          if (io.start) begin
            a     <= io.src_a;
            n     <= io.len;
            sum_q <= '0;
            wcnt  <= SETTLE_CNT;
          end
        end
        S_SETTLE: wcnt <= wcnt - 8'd1;
        S_CAPTURE: begin
          if (!io.abort) begin
            tx_d_q <= io.bus_vo;
            sum_q  <= sum_q + {8'h00, io.bus_vo};
            a      <= a + ASZ'(1);
            n      <= n - ASZ'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io.bus_req = (state == S_FETCH);
  assign io.bus_a   = (state == S_FETCH) ? a : '0;
  assign io.tx_d    = tx_d_q;
  assign io.tx_vld  = tx_vld_q;
  assign io.busy    = (state != S_IDLE);
  assign io.done    = (state == S_DONE);
  assign io.sum     = sum_q;

endmodule

// File: tb/tb_ej32_ram_dump.sv
// Randomised scoreboard bench for ej32_ram_dump.
// It includes a falling-edge SPRAM model and a queue-based reference model.
module tb_ej32_ram_dump;
  localparam int ASZ = 17;
  localparam int S   = 2;
  localparam int MSZ = 1 << ASZ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ej32_ram_dump_if #(.ASZ(ASZ)) bus_if ();
  ej32_ram_dump #(.ASZ(ASZ), .SETTLE(S)) dut (.clk(clk), .rst(rst), .io(bus_if));

  // SPRAM model: the address is sampled on the falling edge, and the data holds until the next read.
  logic [7:0] mem [MSZ];
  logic [7:0] rd_q = 8'h00;
  always @(negedge clk) if (bus_if.bus_req) rd_q <= mem[bus_if.bus_a];
  assign bus_if.bus_vo = rd_q;

  typedef struct { logic [7:0] data; int cyc; } byte_exp_t;
  typedef struct { logic [15:0] sum; int cyc; } done_exp_t;
  byte_exp_t byte_q[$];
  done_exp_t done_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt = 0, bus_req_cnt = 0, vld_cnt = 0;
  bit rand_rdy = 1'b0;
  logic prev_vld = 1'b0, prev_xfer = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected bytes and done events, and check the bus and stream protocol rules.
  always @(negedge clk) begin
    logic xfer;
    byte_exp_t eb;
    done_exp_t ed;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (bus_if.bus_req) bus_req_cnt++;
      if (bus_if.tx_vld)  vld_cnt++;
      if (!bus_if.bus_req) check("bus_a_zero_idle", bus_if.bus_a, 0);
      else                 check("no_bus_req_in_out", bus_if.tx_vld, 0);
      if (prev_vld && !prev_xfer && bus_if.tx_vld) check("tx_d_stable", bus_if.tx_d, prev_d);
      xfer = bus_if.tx_vld && bus_if.tx_rdy && !bus_if.abort;
      if (xfer) begin
        if (byte_q.size() == 0) check("unexpected_byte", 1, 0);
        else begin
          eb = byte_q.pop_front();
          check("byte_data", bus_if.tx_d, eb.data);
          if (eb.cyc >= 0) check("byte_cycle", cyc - start_cyc, eb.cyc);
        end
      end
      if (bus_if.done) begin
        done_cnt++;
        check("busy_in_done", bus_if.busy, 1);
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          ed = done_q.pop_front();
          check("done_sum", bus_if.sum, ed.sum);
          if (ed.cyc >= 0) check("done_cycle", cyc - start_cyc, ed.cyc);
        end
      end
      prev_vld  = bus_if.tx_vld;
      prev_d    = bus_if.tx_d;
      prev_xfer = xfer;
    end
  end

  // Random backpressure generator.
  always @(posedge clk) if (rand_rdy) begin
    #1 bus_if.tx_rdy = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ASZ-1:0] src, input logic [ASZ-1:0] n);
    bus_if.start = 1'b1;
    bus_if.src_a = src;
    bus_if.len   = n;
    start_cyc    = cyc;
    tick(1);
    bus_if.start = 1'b0;
  endtask

  // Reference model: byte i comes from (src+i) mod 2^ASZ, and the checksum is their sum mod 2^16.
  task automatic expect_dump(input int src, input int n, input bit timed);
    int s = 0;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = mem[(src + i) % MSZ];
      s += b;
      byte_q.push_back('{data: b, cyc: timed ? S + 3 + 3 * i : -1});
    end
    done_q.push_back('{sum: s[15:0], cyc: timed ? ((n == 0) ? 1 : S + 3 * n + 1) : -1});
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    if (done_cnt < target) check("done_timeout", 0, 1);
  endtask

  task automatic run_dump(input int src, input int n, input bit timed);
    int target = done_cnt + 1;
    expect_dump(src, n, timed);
    pulse_start(ASZ'(src), ASZ'(n));
    wait_done(target, 8 * n + S + 50);
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, bus_if.bus_req, 0);
    check({tag, "_bus_a"},   bus_if.bus_a,   0);
    check({tag, "_tx_d"},    bus_if.tx_d,    0);
    check({tag, "_tx_vld"},  bus_if.tx_vld,  0);
    check({tag, "_busy"},    bus_if.busy,    0);
    check({tag, "_done"},    bus_if.done,    0);
    check({tag, "_sum"},     bus_if.sum,     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_req, snap_vld, target, k;
    logic [7:0] b0, b1;
    bus_if.start  = 1'b0;
    bus_if.src_a  = '0;
    bus_if.len    = '0;
    bus_if.abort  = 1'b0;
    bus_if.tx_rdy = 1'b1;
    tick(2);
    rst = 1'b0;
    check_all_zero("reset");

    // Basic dump.
    for (int i = 0; i < 4; i++) mem[17'h1400 + i] = 8'(8'h10 + i);
    run_dump(17'h1400, 4, 1);
    check("basic_sum", bus_if.sum, 16'h0046);

    // Zero length.
    snap_req = bus_req_cnt;
    snap_vld = vld_cnt;
    run_dump(17'h0123, 0, 1);
    check("zl_no_bus_req", bus_req_cnt - snap_req, 0);
    check("zl_no_tx_vld", vld_cnt - snap_vld, 0);
    check("zl_sum", bus_if.sum, 0);

    // Backpressure plus a start that must be ignored during the stall.
    for (int i = 0; i < 3; i++) mem[17'h2000 + i] = 8'($urandom);
    bus_if.tx_rdy = 1'b0;
    target = done_cnt + 1;
    expect_dump(17'h2000, 3, 0);
    pulse_start(17'h2000, 3);
    k = 0;
    while (!bus_if.tx_vld && k < 20) begin tick(1); k++; end
    check("bp_first_offer", bus_if.tx_vld, 1);
    snap_req = bus_req_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus_if.start = 1'b1;
        bus_if.src_a = 17'h3000;
        bus_if.len   = 17'd1;
      end
      check("bp_stall_vld", bus_if.tx_vld, 1);
      check("bp_stall_d", bus_if.tx_d, mem[17'h2000]);
      tick(1);
      bus_if.start = 1'b0;
    end
    check("bp_no_bus_req", bus_req_cnt - snap_req, 0);
    bus_if.tx_rdy = 1'b1;
    wait_done(target, 60);
    tick(2);
    check("bp_idle_after", bus_if.busy, 0);

    // Address wrap, then a checksum that overflows.
    mem[17'h1FFFF] = 8'hA5;
    mem[17'h00000] = 8'h3C;
    run_dump(17'h1FFFF, 2, 1);
    check("wrap_sum", bus_if.sum, 16'h00E1);
    for (int i = 0; i < 300; i++) mem[17'h8000 + i] = 8'hFF;
    run_dump(17'h8000, 300, 1);
    check("ff300_sum", bus_if.sum, 16'h2AD4);

    // Abort in the OUT state of byte 1.
    for (int i = 0; i < 4; i++) mem[17'h4000 + i] = 8'($urandom_range(1, 255));
    mem[17'h4010] = 8'h5A;
    b0 = mem[17'h4000];
    b1 = mem[17'h4001];
    target = done_cnt + 1;
    byte_q.push_back('{data: b0, cyc: S + 3});
    done_q.push_back('{sum: 16'(b0) + 16'(b1), cyc: S + 7});
    pulse_start(17'h4000, 4);
    tick(S + 5);
    check("abort_offered", bus_if.tx_vld, 1);
    bus_if.abort = 1'b1;
    tick(1);
    bus_if.abort = 1'b0;
    wait_done(target, 10);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("abort_vld_low", bus_if.tx_vld, 0);
    end
    run_dump(17'h4010, 1, 1);

    // Reset asserted in CAPTURE.
    for (int i = 0; i < 4; i++) mem[17'h5000 + i] = 8'($urandom);
    snap_req = done_cnt;
    pulse_start(17'h5000, 4);
    tick(S + 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("midrst");
    tick(4);
    check("midrst_no_done", done_cnt - snap_req, 0);
    run_dump(17'h5000, 4, 1);

    // Random dumps under random backpressure.
    rand_rdy = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int src = $urandom_range(0, MSZ - 1);
      int n   = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) mem[(src + i) % MSZ] = 8'($urandom);
      run_dump(src, n, 0);
    end
    rand_rdy = 1'b0;
    tick(1);
    bus_if.tx_rdy = 1'b1;
    tick(2);

    check("byte_q_empty", byte_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
